// File: rtl/stream_fifo_pkg.sv
// stream_fifo_pkg
//   Shared helpers for stream_fifo and its storage sub-module.
//   - clog2len / level_w : index and level widths derived from LEN
//   - fifo_idx_inc       : wrap-bit pointer increment for any LEN >= 2
//   No ports (package).
package stream_fifo_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_LEN   = 16;

   // Bits needed to index LEN entries.
   function automatic int unsigned clog2len(input int unsigned len);
      return $clog2(len);
   endfunction

   // Bits needed to count 0..LEN entries.
   function automatic int unsigned level_w(input int unsigned len);
      return $clog2(len + 1);
   endfunction

   // Pointer layout is {wrap, index[aw-1:0]}. The index runs 0..len-1 and the
   // wrap bit toggles each time it rolls over, so equal pointers mean empty
   // and equal index with differing wrap means full. For power-of-2 len this
   // reduces to a plain increment.
   function automatic logic [31:0] fifo_idx_inc(input logic [31:0]   ptr,
                                                input int unsigned   len,
                                                input int unsigned   aw);
      logic [31:0] idx_mask;
      logic [31:0] idx;
      logic [31:0] wrap;
      idx_mask = (32'd1 << aw) - 32'd1;
      idx      = ptr & idx_mask;
      wrap     = ptr & (32'd1 << aw);
      if (idx == len - 32'd1) begin
         idx  = '0;
         wrap = wrap ^ (32'd1 << aw);
      end else begin
         idx  = idx + 32'd1;
      end
      return wrap | idx;
   endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// fifo_ram
//   Simple dual-port RAM, WIDTH x DEPTH, synchronous write, registered read.
//   The read register doubles as the FIFO output register: it loads either
//   from the array (rd_en) or directly from the write data (byp_en).
//   Ports:
//     clk      in   clock
//     wr_en    in   write strobe
//     wr_addr  in   write index
//     wr_data  in   write data (also the bypass source)
//     rd_en    in   load read register from mem[rd_addr]
//     rd_addr  in   read index
//     byp_en   in   load read register from wr_data (ignored when rd_en=1)
//     rd_data  out  read register
module fifo_ram #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   input  logic             byp_en,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end else if (byp_en) begin
         rd_data <= wr_data;
      end
   end

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo
//   Valid/ready first-word-fall-through FIFO, any LEN >= 2. The head entry
//   sits in the RAM's read register; level counts it together with the RAM.
//   Optional feature: define STREAM_FIFO_FLUSH_EN to add the flush input.
//   Ports:
//     clk, rstn      clock, synchronous active-low reset
//     flush          in   clear contents (STREAM_FIFO_FLUSH_EN only)
//     wr_valid/ready/data   write side, handshake = wr_valid & wr_ready
//     rd_valid/ready/data   read side (FWFT), pop = rd_valid & rd_ready
//     level          out  entries held, including the output register
//     almost_full    out  level >= AF_THRESH
//     almost_empty   out  level <= AE_THRESH
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned LEN       = DEF_LEN,
   parameter int unsigned AF_THRESH = LEN - 1,
   parameter int unsigned AE_THRESH = 1
) (
   input  logic                       clk,
   input  logic                       rstn,
`ifdef STREAM_FIFO_FLUSH_EN
   input  logic                       flush,
`endif
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [WIDTH-1:0]           wr_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(LEN+1)-1:0]   level,
   output logic                       almost_full,
   output logic                       almost_empty
);

   localparam int unsigned AW = clog2len(LEN);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned LW = level_w(LEN);
   localparam logic [LW-1:0] LEN_L = LW'(LEN);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] level_q;
   logic          rd_valid_q;
   logic          clr;

   logic push;
   logic pop;
   logic ram_empty;
   logic load;
   logic ld_ram;
   logic bypass;
   logic ram_we;

`ifdef STREAM_FIFO_FLUSH_EN
   assign clr = flush;
`else
   assign clr = 1'b0;
`endif

   assign wr_ready  = rstn && (level_q < LEN_L) && !clr;
   assign push      = wr_valid && wr_ready;
   assign pop       = rd_valid_q && rd_ready;
   assign ram_empty = (wr_ptr == rd_ptr);

   // Output register refills whenever it is empty or being popped. The RAM
   // has priority (older data); only when the RAM is empty does an incoming
   // write skip the array and land directly in the output register.
   assign load   = !rd_valid_q || pop;
   assign ld_ram = load && !ram_empty;
   assign bypass = load && ram_empty && push;
   assign ram_we = push && !bypass;

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         if (ram_we) begin
            wr_ptr <= PW'(fifo_idx_inc(32'(wr_ptr), LEN, AW));
         end
         if (ld_ram) begin
            rd_ptr <= PW'(fifo_idx_inc(32'(rd_ptr), LEN, AW));
         end
         if (load) begin
            rd_valid_q <= ld_ram || bypass;
         end
         if (push && !pop) begin
            level_q <= level_q + 1'b1;
         end else if (pop && !push) begin
            level_q <= level_q - 1'b1;
         end
      end
   end

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (LEN),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_we),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_data),
      .rd_en   (ld_ram),
      .rd_addr (rd_ptr[AW-1:0]),
      .byp_en  (bypass),
      .rd_data (rd_data)
   );

   assign rd_valid     = rd_valid_q;
   assign level        = level_q;
   assign almost_full  = (32'(level_q) >= AF_THRESH);
   assign almost_empty = (32'(level_q) <= AE_THRESH);

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo
//   Directed and randomized stimulus for stream_fifo (WIDTH=8, LEN=5,
//   AF_THRESH=4, AE_THRESH=1). Expected behaviour comes from a queue holding
//   the entries the FIFO should contain, oldest first.
module tb_stream_fifo;

   localparam int unsigned LEN = 5;

   logic       clk;
   logic       rstn;
   logic       flush;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_data;
   logic       rd_valid;
   logic       rd_ready;
   logic [7:0] rd_data;
   logic [2:0] level;
   logic       almost_full;
   logic       almost_empty;

   int unsigned checks;
   int unsigned failures;
   logic [7:0]  model_q[$];

   stream_fifo #(
      .WIDTH     (8),
      .LEN       (LEN),
      .AF_THRESH (4),
      .AE_THRESH (1)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
`ifdef STREAM_FIFO_FLUSH_EN
      .flush        (flush),
`endif
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_data      (rd_data),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the reference queue by the handshakes
   // the FIFO should perform, then compare every output #1 after the edge.
   task automatic cycle(input bit rn, input bit wv, input logic [7:0] wd,
                        input bit rr, input bit fl, input string tag);
      bit do_push;
      bit do_pop;
      int unsigned sz;
      rstn     = rn;
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      flush    = fl;
      @(posedge clk);
      if (!rn || fl) begin
         model_q.delete();
      end else begin
         do_push = wv && (model_q.size() < LEN);
         do_pop  = rr && (model_q.size() > 0);
         if (do_pop)  void'(model_q.pop_front());
         if (do_push) model_q.push_back(wd);
      end
      #1;
      sz = model_q.size();
      check({tag, ".wr_ready"},     32'(wr_ready),     32'(rn && !fl && sz < LEN));
      check({tag, ".rd_valid"},     32'(rd_valid),     32'(sz > 0));
      check({tag, ".level"},        32'(level),        sz);
      check({tag, ".almost_full"},  32'(almost_full),  32'(sz >= 4));
      check({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= 1));
      if (sz > 0) check({tag, ".rd_data"}, 32'(rd_data), 32'(model_q[0]));
   endtask

   initial begin
      int unsigned sent;
      int unsigned rcvd;
      checks   = 0;
      failures = 0;
      rstn     = 1'b0;
      flush    = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      rd_ready = 1'b0;

      // 1: reset, single write, FWFT latency
      cycle(0, 0, 8'h00, 0, 0, "rst0");
      cycle(0, 1, 8'h77, 1, 0, "rst1");
      cycle(1, 1, 8'hA5, 0, 0, "t1_wr");
      check("t1_rd_data_A5", 32'(rd_data), 32'h0000_00A5);
      cycle(1, 0, 8'h00, 1, 0, "t1_pop");

      // 2: fill to full with no reads, hold off 0x06, then drain
      for (int i = 1; i <= 5; i++) cycle(1, 1, 8'(i), 0, 0, "t2_fill");
      check("t2_full_level", 32'(level), 32'd5);
      cycle(1, 1, 8'h06, 0, 0, "t2_holdoff");
      for (int i = 0; i < 6; i++) cycle(1, 0, 8'h00, 1, 0, "t2_drain");

      // 3: randomized stream 0x00..0x1F with gaps on both sides
      sent = 0;
      rcvd = 0;
      for (int c = 0; c < 2000 && rcvd < 32; c++) begin
         bit wv;
         bit rr;
         bit will_push;
         bit will_pop;
         wv = (sent < 32) && ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 2) != 0);
         will_push = wv && (model_q.size() < LEN);
         will_pop  = rr && (model_q.size() > 0);
         if (will_pop) begin
            check("t3_order", 32'(rd_data), rcvd);
            rcvd++;
         end
         cycle(1, wv, 8'(sent), rr, 0, "t3_stream");
         if (will_push) sent++;
      end
      check("t3_all_received", rcvd, 32'd32);

      // 4: simultaneous push+pop at level 2 and at full
      cycle(1, 1, 8'h40, 0, 0, "t4_fill");
      cycle(1, 1, 8'h41, 0, 0, "t4_fill");
      cycle(1, 1, 8'h42, 1, 0, "t4_pushpop2");
      check("t4_level_2", 32'(level), 32'd2);
      for (int i = 0; i < 3; i++) cycle(1, 1, 8'(8'h50 + i), 0, 0, "t4_fill");
      cycle(1, 1, 8'h5F, 1, 0, "t4_pushpop5");
      check("t4_level_4", 32'(level), 32'd4);
      for (int i = 0; i < 4; i++) cycle(1, 0, 8'h00, 1, 0, "t4_drain");

      // 5: reset mid-operation discards contents
      for (int i = 0; i < 3; i++) cycle(1, 1, 8'(8'hC0 + i), 0, 0, "t5_fill");
      cycle(0, 0, 8'h00, 0, 0, "t5_rst");
      cycle(1, 0, 8'h00, 1, 0, "t5_idle");
      check("t5_wr_ready", 32'(wr_ready), 32'd1);
      cycle(1, 1, 8'h3C, 0, 0, "t5_wr");
      check("t5_new_data", 32'(rd_data), 32'h0000_003C);
      cycle(1, 0, 8'h00, 1, 0, "t5_pop");
      cycle(1, 0, 8'h00, 1, 0, "t5_empty");

`ifdef STREAM_FIFO_FLUSH_EN
      // 6: flush drops contents and the write offered with it
      for (int i = 0; i < 4; i++) cycle(1, 1, 8'(8'hE0 + i), 0, 0, "t6_fill");
      cycle(1, 1, 8'hEE, 0, 1, "t6_flush");
      check("t6_level_0", 32'(level), 32'd0);
      cycle(1, 0, 8'h00, 1, 0, "t6_after");
      cycle(1, 1, 8'h12, 0, 0, "t6_wr");
      cycle(1, 0, 8'h00, 1, 0, "t6_pop");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
